// File: rtl/di_block_fifo_term.sv
// Block-capture terminal on the di* host bus: collects one block of 16-bit source
// samples into a FIFO and lets the host drain it through a show-ahead DATA register.
module di_block_fifo_term #(
  parameter logic [15:0] EP_ADDR     = 16'h0010,
  parameter int unsigned DEPTH_LOG2  = 9,
  parameter int unsigned BLOCK_WORDS = 256
) (
  input  logic        if_clock,
  input  logic        resetb,
  input  logic [15:0] diEpAddr,
  input  logic [15:0] diRegAddr,
  input  logic [15:0] diRegDataIn,
  input  logic        diWrite,
  input  logic        diRead,
  input  logic        diReset,
  output logic [15:0] diRegDataOut,
  output logic        rd_ready,
  output logic        wr_ready,
  input  logic [15:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        block_ready,
  output logic        overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] BLOCK_CNT = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST_CNT  = CW'(BLOCK_WORDS - 1);
  localparam logic [CW-1:0] ONE_CNT   = CW'(1);

  localparam logic [15:0] REG_CTRL   = 16'd0;
  localparam logic [15:0] REG_STATUS = 16'd1;
  localparam logic [15:0] REG_COUNT  = 16'd2;
  localparam logic [15:0] REG_DATA   = 16'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic            block_ready_q, block_ready_d;
  logic            overflow_q, overflow_d;

  logic [15:0]     mem [DEPTH];

  logic [CW-1:0]   count;
  logic            sel;
  logic            ctrl_wr;
  logic            start;
  logic            flush;
  logic            data_rd;
  logic            pop;
  logic            push;
  logic            mem_we;
  logic            unused_ctrl_bits;

  assign count            = wr_ptr_q - rd_ptr_q;
  assign sel              = (diEpAddr == EP_ADDR);
  assign ctrl_wr          = sel && diWrite && (diRegAddr == REG_CTRL);
  assign start            = ctrl_wr && diRegDataIn[0];
  assign flush            = ctrl_wr && diRegDataIn[1];
  assign data_rd          = sel && diRead && (diRegAddr == REG_DATA);
  assign pop              = data_rd && (count != '0);
  assign unused_ctrl_bits = ^diRegDataIn[15:2];

  assign src_ready = (state_q == ST_COLLECT) && (count != FULL_CNT) && (wcnt_q < BLOCK_CNT);
  assign push      = src_valid && src_ready;
  // Samples only land in the FIFO when no clear of any kind wins this cycle
  assign mem_we    = push && !diReset && !start && !flush;

  assign block_ready = block_ready_q;
  assign overflow    = overflow_q;
  assign wr_ready    = sel;

  // Host-visible read mux; a deselected terminal drives all zeros
  always_comb begin
    diRegDataOut = '0;
    rd_ready     = 1'b0;
    if (sel) begin
      rd_ready = 1'b1;
      unique case (diRegAddr)
        REG_STATUS: diRegDataOut = {12'b0, overflow_q, block_ready_q, state_q};
        REG_COUNT:  diRegDataOut = 16'(count);
        REG_DATA: begin
          if (count != '0) diRegDataOut = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
          rd_ready = (count > ONE_CNT) || ((count == ONE_CNT) && !diRead);
        end
        default:    diRegDataOut = '0;
      endcase
    end
  end

  // Next-state: terminal clear, then collect start, then flush, then normal push/pop
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    wcnt_d        = wcnt_q;
    block_ready_d = block_ready_q;
    overflow_d    = overflow_q;

    if (diReset) begin
      state_d       = ST_IDLE;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      wcnt_d        = '0;
      block_ready_d = 1'b0;
      overflow_d    = 1'b0;
    end else if (start) begin
      state_d       = ST_COLLECT;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      wcnt_d        = '0;
      block_ready_d = 1'b0;
      overflow_d    = 1'b0;
    end else if (flush) begin
      rd_ptr_d = wr_ptr_q;
      // An empty READY buffer has nothing left to drain
      if (state_q == ST_READY) begin
        state_d       = ST_IDLE;
        block_ready_d = 1'b0;
      end
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + ONE_CNT;
        if (wcnt_q != BLOCK_CNT) wcnt_d = wcnt_q + ONE_CNT;
      end
      if (pop) rd_ptr_d = rd_ptr_q + ONE_CNT;
      if ((state_q != ST_IDLE) && src_valid && !src_ready) overflow_d = 1'b1;

      unique case (state_q)
        ST_COLLECT: begin
          if (push && (wcnt_q == LAST_CNT)) begin
            state_d       = ST_READY;
            block_ready_d = 1'b1;
          end
        end
        ST_READY: begin
          if (pop && (count == ONE_CNT)) begin
            state_d       = ST_IDLE;
            block_ready_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wcnt_q        <= '0;
      block_ready_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wcnt_q        <= wcnt_d;
      block_ready_q <= block_ready_d;
      overflow_q    <= overflow_d;
    end
  end

  // Sample storage; contents are only meaningful between the pointers
  always_ff @(posedge if_clock) begin
    if (mem_we) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= src_data;
  end

endmodule

// File: tb/tb_di_block_fifo_term.sv
// Directed bench for di_block_fifo_term: a default-size terminal at 0x0010 and a
// 16-deep/16-word terminal at 0x0020 share the host bus and the source.
module tb_di_block_fifo_term;

  localparam logic [15:0] EPA = 16'h0010;
  localparam logic [15:0] EPB = 16'h0020;

  logic        if_clock = 1'b0;
  logic        resetb   = 1'b0;
  logic [15:0] diEpAddr = '0;
  logic [15:0] diRegAddr = '0;
  logic [15:0] diRegDataIn = '0;
  logic        diWrite = 1'b0;
  logic        diRead  = 1'b0;
  logic        diReset = 1'b0;
  logic [15:0] src_data = '0;
  logic        src_valid = 1'b0;

  logic [15:0] dout_a, dout_b;
  logic        rd_ready_a, rd_ready_b, wr_ready_a, wr_ready_b;
  logic        src_ready_a, src_ready_b, block_ready_a, block_ready_b;
  logic        overflow_a, overflow_b;

  wire  [15:0] dout = dout_a | dout_b;
  wire         rr   = rd_ready_a | rd_ready_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 if_clock = ~if_clock;

  di_block_fifo_term #(.EP_ADDR(EPA), .DEPTH_LOG2(9), .BLOCK_WORDS(256)) u_a (
    .if_clock(if_clock), .resetb(resetb), .diEpAddr(diEpAddr), .diRegAddr(diRegAddr),
    .diRegDataIn(diRegDataIn), .diWrite(diWrite), .diRead(diRead), .diReset(diReset),
    .diRegDataOut(dout_a), .rd_ready(rd_ready_a), .wr_ready(wr_ready_a),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready_a),
    .block_ready(block_ready_a), .overflow(overflow_a));

  di_block_fifo_term #(.EP_ADDR(EPB), .DEPTH_LOG2(4), .BLOCK_WORDS(16)) u_b (
    .if_clock(if_clock), .resetb(resetb), .diEpAddr(diEpAddr), .diRegAddr(diRegAddr),
    .diRegDataIn(diRegDataIn), .diWrite(diWrite), .diRead(diRead), .diReset(diReset),
    .diRegDataOut(dout_b), .rd_ready(rd_ready_b), .wr_ready(wr_ready_b),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready_b),
    .block_ready(block_ready_b), .overflow(overflow_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge if_clock);
    #1;
  endtask

  task automatic peek(input logic [15:0] ep, input logic [15:0] addr);
    diEpAddr  = ep;
    diRegAddr = addr;
    diRead    = 1'b0;
    #1;
  endtask

  task automatic wr_reg(input logic [15:0] ep, input logic [15:0] addr, input logic [15:0] data);
    diEpAddr    = ep;
    diRegAddr   = addr;
    diRegDataIn = data;
    diWrite     = 1'b1;
    #1;
    step();
    diWrite = 1'b0;
  endtask

  task automatic pop(input logic [15:0] ep, output logic [15:0] d, output logic r);
    diEpAddr  = ep;
    diRegAddr = 16'd3;
    diRead    = 1'b1;
    #1;
    d = dout;
    r = rr;
    step();
    diRead = 1'b0;
  endtask

  task automatic stream(input int n, input logic [15:0] base, output int accepted);
    accepted = 0;
    for (int i = 0; i < n; i++) begin
      src_data  = base + 16'(i);
      src_valid = 1'b1;
      #1;
      if (src_ready_a | src_ready_b) accepted++;
      step();
    end
    src_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic        r;
    int          acc;

    // Power-on reset state
    #2;
    peek(EPA, 16'd1);  check("por_status", 32'(dout), 32'h0);
    peek(EPA, 16'd2);  check("por_count", 32'(dout), 32'h0);
    check("por_src_ready", 32'(src_ready_a), 32'h0);
    #10 resetb = 1'b1;
    step();

    // T1: async reset while collecting
    wr_reg(EPA, 16'd0, 16'h0001);
    stream(10, 16'h0000, acc);
    peek(EPA, 16'd2);  check("t1_count_pre", 32'(dout), 32'd10);
    peek(EPA, 16'd1);  check("t1_status_pre", 32'(dout), 32'h1);
    check("t1_src_ready_pre", 32'(src_ready_a), 32'h1);
    resetb = 1'b0;
    #2;
    check("t1_src_ready_in_rst", 32'(src_ready_a), 32'h0);
    resetb = 1'b1;
    step();
    peek(EPA, 16'd1);  check("t1_status", 32'(dout), 32'h0);
    peek(EPA, 16'd2);  check("t1_count", 32'(dout), 32'h0);
    check("t1_src_ready", 32'(src_ready_a), 32'h0);
    check("t1_block_ready", 32'(block_ready_a), 32'h0);
    check("t1_overflow", 32'(overflow_a), 32'h0);

    // T2: full 256-word block then complete drain
    wr_reg(EPA, 16'd0, 16'h0001);
    stream(256, 16'h0000, acc);
    check("t2_accepted", 32'(acc), 32'd256);
    check("t2_block_ready", 32'(block_ready_a), 32'h1);
    peek(EPA, 16'd1);  check("t2_status", 32'(dout), 32'h6);
    peek(EPA, 16'd2);  check("t2_count", 32'(dout), 32'd256);
    check("t2_src_ready", 32'(src_ready_a), 32'h0);
    for (int i = 0; i < 256; i++) begin
      pop(EPA, d, r);
      check("t2_pop_data", 32'(d), 32'(i));
    end
    peek(EPA, 16'd1);  check("t2_status_drained", 32'(dout), 32'h0);
    check("t2_block_ready_drained", 32'(block_ready_a), 32'h0);
    peek(EPA, 16'd2);  check("t2_count_drained", 32'(dout), 32'h0);

    // T4: rd_ready at the last word, empty DATA read
    wr_reg(EPA, 16'd0, 16'h0001);
    stream(3, 16'h00A0, acc);
    pop(EPA, d, r);    check("t4_pop0", 32'(d), 32'h00A0);
    pop(EPA, d, r);    check("t4_pop1", 32'(d), 32'h00A1);
    peek(EPA, 16'd3);
    check("t4_rd_ready_idle", 32'(rr), 32'h1);
    check("t4_head", 32'(dout), 32'h00A2);
    pop(EPA, d, r);
    check("t4_pop2", 32'(d), 32'h00A2);
    check("t4_rd_ready_popping", 32'(r), 32'h0);
    peek(EPA, 16'd2);  check("t4_count_empty", 32'(dout), 32'h0);
    peek(EPA, 16'd3);
    check("t4_empty_data", 32'(dout), 32'h0);
    check("t4_empty_rd_ready", 32'(rr), 32'h0);
    peek(EPA, 16'd1);  check("t4_status", 32'(dout), 32'h1);

    // T5: push and pop in the same cycle at count 5
    stream(5, 16'h00B0, acc);
    peek(EPA, 16'd2);  check("t5_count_pre", 32'(dout), 32'd5);
    diEpAddr  = EPA;
    diRegAddr = 16'd3;
    diRead    = 1'b1;
    src_data  = 16'h00B5;
    src_valid = 1'b1;
    #1;
    check("t5_concurrent_head", 32'(dout), 32'h00B0);
    step();
    diRead    = 1'b0;
    src_valid = 1'b0;
    peek(EPA, 16'd2);  check("t5_count_post", 32'(dout), 32'd5);
    for (int i = 1; i < 6; i++) begin
      pop(EPA, d, r);
      check("t5_order", 32'(d), 32'h00B0 + 32'(i));
    end
    peek(EPA, 16'd2);  check("t5_count_end", 32'(dout), 32'h0);

    // T6: bus traffic to an unused endpoint
    stream(2, 16'h00C0, acc);
    diEpAddr  = 16'h0011;
    diRegAddr = 16'd3;
    diRead    = 1'b1;
    #1;
    check("t6_dout_a", 32'(dout_a), 32'h0);
    check("t6_dout_b", 32'(dout_b), 32'h0);
    check("t6_rd_ready", 32'(rr), 32'h0);
    check("t6_wr_ready", 32'(wr_ready_a | wr_ready_b), 32'h0);
    step();
    diRead = 1'b0;
    wr_reg(16'h0011, 16'd0, 16'h0003);
    peek(EPA, 16'd2);  check("t6_count_kept", 32'(dout), 32'd2);
    check("t6_wr_ready_sel", 32'(wr_ready_a), 32'h1);
    peek(EPA, 16'd1);  check("t6_status_kept", 32'(dout), 32'h1);
    peek(EPA, 16'd3);  check("t6_head_kept", 32'(dout), 32'h00C0);

    // Synchronous terminal clear reaches the terminal even when deselected
    diEpAddr = 16'h0011;
    diReset  = 1'b1;
    step();
    diReset = 1'b0;
    peek(EPA, 16'd1);  check("direset_status", 32'(dout), 32'h0);
    peek(EPA, 16'd2);  check("direset_count", 32'(dout), 32'h0);

    // T3: small terminal, no drain, 20 offered samples
    wr_reg(EPB, 16'd0, 16'h0001);
    stream(20, 16'h0100, acc);
    check("t3_accepted", 32'(acc), 32'd16);
    check("t3_overflow", 32'(overflow_b), 32'h1);
    check("t3_block_ready", 32'(block_ready_b), 32'h1);
    peek(EPB, 16'd1);  check("t3_status", 32'(dout), 32'hE);
    peek(EPB, 16'd2);  check("t3_count", 32'(dout), 32'd16);
    for (int i = 0; i < 4; i++) begin
      pop(EPB, d, r);
      check("t3_pop", 32'(d), 32'h0100 + 32'(i));
    end
    check("t3_overflow_sticky", 32'(overflow_b), 32'h1);
    wr_reg(EPB, 16'd0, 16'h0001);
    check("t3_overflow_cleared", 32'(overflow_b), 32'h0);
    peek(EPB, 16'd1);  check("t3_status_restart", 32'(dout), 32'h1);
    peek(EPB, 16'd2);  check("t3_count_restart", 32'(dout), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
